t_ff_bank: RTL and testbench
============================

# t_ff_bank

Parametrised bank of WIDTH toggle flip-flops with a shared clock and reset. It extends the single-bit T flip-flop in three ways: a per-bit toggle mask, built-in up/down counting (T-flip-flop counter semantics), and parallel load. It also flags the terminal count. It is the general-purpose toggle/count register for the design's small counters and divider chains.

## Interface
- WIDTH, 8: number of flip-flops; legal range 2..32.
- SATURATE, 0: 0 means counting wraps at the boundary; 1 means counting holds at the boundary.
- RST_VAL, 0: value loaded into q on reset. Width WIDTH; must fit in WIDTH bits.

- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-high; forces q=RST_VAL and tc=0 immediately while high.
- en  in  1  synchronous enable; 0 holds q and drives tc to 0 on the next edge.
- mode  in  2  operation select, sampled on the clk edge with en=1.
- t  in  WIDTH  per-bit toggle mask; used in TOGGLE mode only.
- d  in  WIDTH  parallel load data; used in LOAD mode only.
- q  out  WIDTH  flip-flop state; registered; reset value RST_VAL.
- tc  out  1  terminal-count flag; registered; reset value 0.

## Operation
- Priority on each rising edge:
  1. rst
  2. en=0 (hold)
  3. mode decode
- mode=2'b00 TOGGLE:
  - q <= q ^ t: bit i inverts when t[i]=1 and holds otherwise.
  - t=0 is a pure hold.
  - tc <= 0.
- mode=2'b01 UP:
  - Bit i toggles when all bits below i are 1 (bit 0 always toggles), which is q <= q+1 modulo 2^WIDTH.
  - At the boundary q = all ones:
    - SATURATE=0: q wraps to 0 and tc <= 1.
    - SATURATE=1: q holds all ones and tc <= 1.
  - Otherwise tc <= 0.
- mode=2'b10 DOWN:
  - Bit i toggles when all bits below i are 0, which is q <= q-1 modulo 2^WIDTH.
  - At the boundary q = 0:
    - SATURATE=0: q wraps to all ones and tc <= 1.
    - SATURATE=1: q holds 0 and tc <= 1.
  - Otherwise tc <= 0.
- mode=2'b11 LOAD:
  - q <= d and tc <= 0, whatever the value of d, including boundary values.
- Only the current q decides tc. A LOAD of all ones followed by UP gives tc on the UP edge, not on the LOAD edge.
- Saturating counts held at the boundary re-assert tc on every enabled counting edge, so tc stays high continuously.
- A mode change between cycles needs no recovery. Each edge uses only the current q and the current inputs.
- All arithmetic is unsigned and WIDTH bits wide. There is no carry out beyond tc.

## Timing
- Latency is 1 clk for every mode: inputs sampled at edge k appear on q/tc after edge k.
- tc is aligned with the q update it describes. For example, in UP wrap mode q becomes 0 and tc=1 in the same cycle.
- tc is a single-cycle pulse in wrap mode. It stays high for as many cycles as the boundary count persists in saturate mode.
- rst acts asynchronously:
  - Assertion sets q=RST_VAL and tc=0 without waiting for clk, including in the middle of a count.
  - Deassertion is seen at the next rising edge. The first edge with rst low performs a normal operation.
- en, mode, t and d must be stable around the clk edge. There is no internal registering of inputs.
- Inputs have no combinational path to any output.

## Test plan
- Reset behaviour, with RST_VAL=8'hA5: assert rst mid-cycle while counting -> q=8'hA5 and tc=0 before the next edge. Release rst, en=0 for 3 edges -> q stays 8'hA5.
- TOGGLE mode: load q=8'h0F, then apply t=8'hFF, then t=8'h81, then t=8'h00 on successive edges -> q=8'hF0, then 8'h71, then 8'h71; tc=0 throughout.
- UP wrap, with SATURATE=0: load 8'hFD, then apply UP for 4 edges -> q=FE, FF, 00, 01; tc=0, 0, 1, 0.
- DOWN saturate, with SATURATE=1: load 8'h02, then apply DOWN for 4 edges -> q=01, 00, 00, 00; tc=0, 0, 1, 1. Then en=0 -> q=00 and tc=0.
- Enable and mode interleave:
  - Run UP from 8'h7F with en toggling 1,0,1 -> q=80, 80, 81.
  - Switch to LOAD with d=8'hFF -> q=FF and tc=0.
  - Next UP edge -> q=00 and tc=1 (wrap mode).
- Parameter sweep: WIDTH=2 and WIDTH=32, each with both SATURATE values. Run a full up cycle then a full down cycle (for WIDTH=32, preload near each boundary) -> tc occurs exactly at the boundary transitions and q matches a reference counter.

Source files
------------

// File: rtl/t_ff_bank.sv
// Bank of WIDTH toggle flip-flops with per-bit toggle mask, up/down counting,
// parallel load and a registered terminal-count flag aligned with q.
module t_ff_bank #(
  parameter int               WIDTH    = 8,
  parameter bit               SATURATE = 1'b0,
  parameter logic [WIDTH-1:0] RST_VAL  = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] t,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             tc
);

  localparam logic [1:0] MODE_TOGGLE = 2'b00;
  localparam logic [1:0] MODE_UP     = 2'b01;
  localparam logic [1:0] MODE_DOWN   = 2'b10;
  localparam logic [1:0] MODE_LOAD   = 2'b11;

  // Counter as T flip-flops: bit i toggles while every lower bit is 1.
  // The MSB of the result is the carry out, i.e. "q is all ones".
  function automatic logic [WIDTH:0] up_toggle(input logic [WIDTH-1:0] v);
    logic             carry;
    logic [WIDTH-1:0] tg;
    carry = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      tg[i] = carry;
      carry = carry & v[i];
    end
    return {carry, tg};
  endfunction

  // Down counting: bit i toggles while every lower bit is 0; MSB flags q == 0.
  function automatic logic [WIDTH:0] down_toggle(input logic [WIDTH-1:0] v);
    logic             borrow;
    logic [WIDTH-1:0] tg;
    borrow = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      tg[i]  = borrow;
      borrow = borrow & ~v[i];
    end
    return {borrow, tg};
  endfunction

  // A saturating counter at its boundary simply stops toggling.
  function automatic logic [WIDTH-1:0] sat_toggle(input logic [WIDTH-1:0] tg,
                                                  input logic             at_bound);
    return (SATURATE && at_bound) ? '0 : tg;
  endfunction

  logic [WIDTH:0]   up_p0;
  logic [WIDTH:0]   dn_p0;
  logic [WIDTH-1:0] tog_p0;
  logic             tc_nxt_p0;

  assign up_p0 = up_toggle(q);
  assign dn_p0 = down_toggle(q);

  always_comb begin
    tog_p0    = '0;
    tc_nxt_p0 = 1'b0;
    unique case (mode)
      MODE_TOGGLE: tog_p0 = t;
      MODE_UP: begin
        tog_p0    = sat_toggle(up_p0[WIDTH-1:0], up_p0[WIDTH]);
        tc_nxt_p0 = up_p0[WIDTH];
      end
      MODE_DOWN: begin
        tog_p0    = sat_toggle(dn_p0[WIDTH-1:0], dn_p0[WIDTH]);
        tc_nxt_p0 = dn_p0[WIDTH];
      end
      MODE_LOAD: tog_p0 = '0;
      default:   tog_p0 = '0;
    endcase
  end

  // Stage p0 -> register: q and tc update together on the enabled edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q  <= RST_VAL;
      tc <= 1'b0;
    end else if (!en) begin
      tc <= 1'b0;
    end else begin
      tc <= tc_nxt_p0;
      q  <= (mode == MODE_LOAD) ? d : (q ^ tog_p0);
    end
  end

endmodule

// File: tb/tb_t_ff_bank.sv
// Scoreboard bench for t_ff_bank: six instances covering WIDTH 8/2/32 and both
// SATURATE settings; stimulus pushes expectations, a monitor pops and checks.
module tb_t_ff_bank;

  localparam logic [1:0] TOG = 2'b00;
  localparam logic [1:0] UP  = 2'b01;
  localparam logic [1:0] DN  = 2'b10;
  localparam logic [1:0] LD  = 2'b11;

  localparam int WS [6] = '{8, 8, 2, 2, 32, 32};
  localparam bit SS [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

  typedef struct {
    int          id;
    logic [31:0] q;
    logic        tc;
    string       name;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [5:0]  en_a;
  logic [1:0]  mode_a [6];
  logic [31:0] t_a    [6];
  logic [31:0] d_a    [6];
  logic [31:0] qa     [6];
  logic        tca    [6];

  exp_t sb[$];
  event sample_ev;
  int   n_chk;
  int   n_pass;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 6; g++) begin : g_dut
    localparam logic [31:0]    RV32 = (g == 0) ? 32'hA5 : 32'h0;
    localparam logic [WS[g]-1:0] RV = RV32[WS[g]-1:0];
    logic [WS[g]-1:0] qn;
    t_ff_bank #(.WIDTH(WS[g]), .SATURATE(SS[g]), .RST_VAL(RV)) u_dut (
      .clk (clk),
      .rst (rst),
      .en  (en_a[g]),
      .mode(mode_a[g]),
      .t   (t_a[g][WS[g]-1:0]),
      .d   (d_a[g][WS[g]-1:0]),
      .q   (qn),
      .tc  (tca[g])
    );
    assign qa[g] = 32'(qn);
  end

  // Monitor: outputs are compared 1 time unit after each edge or sample request
  always begin
    exp_t e;
    @(posedge clk or sample_ev);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      n_chk++;
      if (qa[e.id] === e.q && tca[e.id] === e.tc) n_pass++;
      else $display("FAIL %s (dut %0d): got q=%h tc=%b, expected q=%h tc=%b",
                    e.name, e.id, qa[e.id], tca[e.id], e.q, e.tc);
    end
  end

  task automatic expect_now(input int id, input logic [31:0] eq, input logic etc,
                            input string nm);
    sb.push_back('{id: id, q: eq, tc: etc, name: nm});
  endtask

  task automatic step(input int id, input logic e, input logic [1:0] m,
                      input logic [31:0] tv, input logic [31:0] dv,
                      input logic [31:0] eq, input logic etc, input string nm);
    @(negedge clk);
    en_a       = '0;
    en_a[id]   = e;
    mode_a[id] = m;
    t_a[id]    = tv;
    d_a[id]    = dv;
    expect_now(id, eq, etc, nm);
  endtask

  // Plain arithmetic reference counter for the parameter sweep
  function automatic void model(input int w, input bit s, input logic [1:0] m,
                                input logic [31:0] qc, input logic [31:0] dv,
                                output logic [31:0] nq, output logic ntc);
    logic [31:0] mask;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
    nq  = qc;
    ntc = 1'b0;
    case (m)
      UP: begin
        if (qc == mask) begin ntc = 1'b1; nq = s ? qc : 32'h0; end
        else nq = (qc + 32'h1) & mask;
      end
      DN: begin
        if (qc == 32'h0) begin ntc = 1'b1; nq = s ? 32'h0 : mask; end
        else nq = (qc - 32'h1) & mask;
      end
      LD: nq = dv & mask;
      default: nq = qc;
    endcase
  endfunction

  initial begin
    int          w;
    bit          s;
    logic [31:0] eq;
    logic        etc;
    logic [31:0] start;
    n_chk  = 0;
    n_pass = 0;
    rst    = 1'b0;
    en_a   = '0;
    for (int i = 0; i < 6; i++) begin
      mode_a[i] = TOG;
      t_a[i]    = '0;
      d_a[i]    = '0;
    end

    // Reset state of every instance
    #1 rst = 1'b1;
    #2;
    expect_now(0, 32'hA5, 1'b0, "reset_val_a5");
    for (int i = 1; i < 6; i++) expect_now(i, 32'h0, 1'b0, "reset_val_0");
    ->sample_ev;
    @(negedge clk);
    rst = 1'b0;

    // Asynchronous reset in the middle of a count
    step(0, 1'b1, LD, 0, 32'h10, 32'h10, 1'b0, "pre_rst_load");
    step(0, 1'b1, UP, 0, 0, 32'h11, 1'b0, "pre_rst_up1");
    step(0, 1'b1, UP, 0, 0, 32'h12, 1'b0, "pre_rst_up2");
    @(posedge clk);
    #3 rst = 1'b1;
    expect_now(0, 32'hA5, 1'b0, "async_rst_mid");
    ->sample_ev;
    @(negedge clk);
    en_a = '0;
    rst  = 1'b0;
    for (int k = 0; k < 3; k++) step(0, 1'b0, UP, 0, 0, 32'hA5, 1'b0, "post_rst_hold");

    // TOGGLE mode
    step(0, 1'b1, LD,  0,     32'h0F, 32'h0F, 1'b0, "tog_load");
    step(0, 1'b1, TOG, 32'hFF, 0,     32'hF0, 1'b0, "tog_ff");
    step(0, 1'b1, TOG, 32'h81, 0,     32'h71, 1'b0, "tog_81");
    step(0, 1'b1, TOG, 32'h00, 0,     32'h71, 1'b0, "tog_00");

    // UP with wrap
    step(0, 1'b1, LD, 0, 32'hFD, 32'hFD, 1'b0, "upw_load");
    step(0, 1'b1, UP, 0, 0, 32'hFE, 1'b0, "upw_fe");
    step(0, 1'b1, UP, 0, 0, 32'hFF, 1'b0, "upw_ff");
    step(0, 1'b1, UP, 0, 0, 32'h00, 1'b1, "upw_wrap");
    step(0, 1'b1, UP, 0, 0, 32'h01, 1'b0, "upw_01");

    // DOWN with saturation
    step(1, 1'b1, LD, 0, 32'h02, 32'h02, 1'b0, "dns_load");
    step(1, 1'b1, DN, 0, 0, 32'h01, 1'b0, "dns_01");
    step(1, 1'b1, DN, 0, 0, 32'h00, 1'b0, "dns_00");
    step(1, 1'b1, DN, 0, 0, 32'h00, 1'b1, "dns_hold1");
    step(1, 1'b1, DN, 0, 0, 32'h00, 1'b1, "dns_hold2");
    step(1, 1'b0, DN, 0, 0, 32'h00, 1'b0, "dns_en0");

    // UP saturation: tc only from the current q, not on the LOAD edge
    step(1, 1'b1, LD, 0, 32'hFF, 32'hFF, 1'b0, "ups_load_ff");
    step(1, 1'b1, UP, 0, 0, 32'hFF, 1'b1, "ups_hold1");
    step(1, 1'b1, UP, 0, 0, 32'hFF, 1'b1, "ups_hold2");
    step(1, 1'b0, UP, 0, 0, 32'hFF, 1'b0, "ups_en0");

    // Enable and mode interleave
    step(0, 1'b1, LD, 0, 32'h7F, 32'h7F, 1'b0, "mix_load");
    step(0, 1'b1, UP, 0, 0, 32'h80, 1'b0, "mix_up_en1");
    step(0, 1'b0, UP, 0, 0, 32'h80, 1'b0, "mix_up_en0");
    step(0, 1'b1, UP, 0, 0, 32'h81, 1'b0, "mix_up_en1b");
    step(0, 1'b1, LD, 0, 32'hFF, 32'hFF, 1'b0, "mix_load_ff");
    step(0, 1'b1, UP, 0, 0, 32'h00, 1'b1, "mix_wrap");
    step(0, 1'b1, DN, 0, 0, 32'hFF, 1'b1, "mix_dn_wrap");

    // Parameter sweep against the reference counter
    for (int g = 2; g < 6; g++) begin
      w     = WS[g];
      s     = SS[g];
      start = (w == 2) ? 32'h0 : 32'hFFFF_FFFD;
      step(g, 1'b1, LD, 0, start, start, 1'b0, "sweep_load_up");
      eq = start;
      for (int k = 0; k < 5; k++) begin
        model(w, s, UP, eq, 0, eq, etc);
        step(g, 1'b1, UP, 0, 0, eq, etc, "sweep_up");
      end
      start = (w == 2) ? 32'h3 : 32'h2;
      step(g, 1'b1, LD, 0, start, start, 1'b0, "sweep_load_dn");
      eq = start;
      for (int k = 0; k < 5; k++) begin
        model(w, s, DN, eq, 0, eq, etc);
        step(g, 1'b1, DN, 0, 0, eq, etc, "sweep_dn");
      end
    end

    // Drain the scoreboard with a bounded wait
    for (int k = 0; k < 10 && sb.size() > 0; k++) @(posedge clk);
    #3;
    if (sb.size() > 0) begin
      $display("FAIL drain: got %0d pending expectations, expected 0", sb.size());
      n_chk += sb.size();
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
